// File: rtl/aes_pkg.sv
// Shared AES inverse-cipher definitions: block geometry, GF(2^8) helpers,
// inverse round transforms, FSM state type and the inverse S-box table.
package aes_pkg;

    localparam int NB          = 4;
    localparam int AES_BLOCK_W = 128;
    localparam int RK_IDX_W    = 4;
    localparam logic [7:0] GF_POLY = 8'h1B;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_FINAL,
        ST_DONE
    } fsm_state_t;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
    endfunction

    // Multiply by a 4-bit constant, enough for the 09/0b/0d/0e coefficients.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (k[0] ? a : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
               (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
    endfunction

    function automatic logic [AES_BLOCK_W-1:0] inv_shift_rows(input logic [AES_BLOCK_W-1:0] s);
        logic [AES_BLOCK_W-1:0] o;
        o = '0;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+NB)%NB)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [AES_BLOCK_W-1:0] inv_mix_columns(input logic [AES_BLOCK_W-1:0] s);
        logic [AES_BLOCK_W-1:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < NB; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 32] = {
                gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9),
                gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd),
                gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb),
                gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he)
            };
        end
        return o;
    endfunction

endpackage

// File: rtl/inv_sub_bytes.sv
// Sixteen parallel inverse S-box lookups over a full AES block.
module inv_sub_bytes
    import aes_pkg::*;
(
    input  logic [AES_BLOCK_W-1:0] din,
    output logic [AES_BLOCK_W-1:0] dout
);

    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign dout[8*i +: 8] = INV_SBOX[din[8*i +: 8]];
    end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES decryption, one round per clock, round keys fetched by index
// from an external key store that answers combinationally.
module aes_inv_cipher_iter
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] in_data,
    output logic [RK_IDX_W-1:0]    rk_idx,
    input  logic [AES_BLOCK_W-1:0] rk,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_data,
    output logic                   busy
);

    if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
        $error("aes_inv_cipher_iter: NR must be 10, 12 or 14");
    end

    localparam logic [RK_IDX_W-1:0] LAST_IDX = RK_IDX_W'(NR);
    localparam logic [RK_IDX_W-1:0] FIRST_RND = RK_IDX_W'(NR - 1);

    fsm_state_t st, st_nxt;
    logic [RK_IDX_W-1:0]    cnt;
    logic [AES_BLOCK_W-1:0] blk;
    logic [AES_BLOCK_W-1:0] shifted;
    logic [AES_BLOCK_W-1:0] subbed;
    logic [AES_BLOCK_W-1:0] keyed;

    assign shifted = inv_shift_rows(blk);

    inv_sub_bytes u_inv_sub_bytes (
        .din  (shifted),
        .dout (subbed)
    );

    assign keyed = subbed ^ rk;

    always_ff @(posedge clk) begin
        if (!rst_n) st <= ST_IDLE;
        else        st <= st_nxt;
    end

    always_comb begin
        st_nxt    = st;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        rk_idx    = LAST_IDX;
        case (st)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) st_nxt = ST_ROUND;
            end
            ST_ROUND: begin
                rk_idx = cnt;
                if (cnt == 4'd1) st_nxt = ST_FINAL;
            end
            ST_FINAL: begin
                rk_idx = '0;
                st_nxt = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) st_nxt = ST_IDLE;
            end
            default: st_nxt = ST_IDLE;
        endcase
    end

    // The final round skips InvMixColumns and lands directly in the output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= LAST_IDX;
            blk      <= '0;
            out_data <= '0;
        end else begin
            case (st)
                ST_IDLE: begin
                    if (in_valid) begin
                        blk <= in_data ^ rk;
                        cnt <= FIRST_RND;
                    end
                end
                ST_ROUND: begin
                    blk <= inv_mix_columns(keyed);
                    if (cnt != 4'd1) cnt <= cnt - 4'd1;
                end
                ST_FINAL: out_data <= keyed;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed bench for the iterative AES decryptor: FIPS-197 vectors at NR=10/14,
// backpressure, back-to-back, busy-input ignore and mid-operation reset.
module tb_aes_inv_cipher_iter;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0]   in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] in_data  [2];
    logic [127:0] rk       [2];
    logic [127:0] out_data [2];
    logic [3:0]   rk_idx   [2];
    logic [127:0] ks       [2][15];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign rk[0] = (rk_idx[0] < 4'd15) ? ks[0][rk_idx[0]] : '0;
    assign rk[1] = (rk_idx[1] < 4'd15) ? ks[1][rk_idx[1]] : '0;

    aes_inv_cipher_iter #(.NR(10)) dut10 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .rk_idx(rk_idx[0]), .rk(rk[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0])
    );

    aes_inv_cipher_iter #(.NR(14)) dut14 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .rk_idx(rk_idx[1]), .rk(rk[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1])
    );

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Forward round (SubBytes+ShiftRows, optional MixColumns) used to build ciphertexts.
    function automatic logic [127:0] encRound(input logic [127:0] s, input bit mix);
        logic [127:0] t;
        logic [7:0] a0, a1, a2, a3;
        t = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[127-8*(r+4*c) -: 8] = SBOX[s[127-8*(r+4*((c+r)%4)) -: 8]];
        if (mix) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[127-32*c -: 8]; a1 = t[119-32*c -: 8];
                a2 = t[111-32*c -: 8]; a3 = t[103-32*c -: 8];
                t[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                     a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                     a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                     xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
            end
        end
        return t;
    endfunction

    function automatic logic [127:0] encrypt(input int w, input logic [127:0] pt, input int nr);
        logic [127:0] s;
        s = pt ^ ks[w][0];
        for (int r = 1; r < nr; r++) s = encRound(s, 1'b1) ^ ks[w][r];
        return encRound(s, 1'b0) ^ ks[w][nr];
    endfunction

    task automatic expandKey(input int w, input logic [255:0] key, input int nk);
        logic [31:0] wd [60];
        logic [31:0] tmp;
        logic [7:0]  rc;
        int nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) begin
                wd[i] = key[255-32*i -: 32];
            end else begin
                tmp = wd[i-1];
                if (i % nk == 0) begin
                    tmp = {SBOX[tmp[23:16]] ^ rc, SBOX[tmp[15:8]], SBOX[tmp[7:0]], SBOX[tmp[31:24]]};
                    rc  = xt(rc);
                end else if (nk > 6 && i % nk == 4) begin
                    tmp = {SBOX[tmp[31:24]], SBOX[tmp[23:16]], SBOX[tmp[15:8]], SBOX[tmp[7:0]]};
                end
                wd[i] = wd[i-nk] ^ tmp;
            end
        end
        for (int r = 0; r <= nr; r++) ks[w][r] = {wd[4*r], wd[4*r+1], wd[4*r+2], wd[4*r+3]};
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic applyStimulus(input int w, input logic [127:0] ct, output logic [3:0] idx0);
        int n;
        n = 0;
        in_valid[w] = 1'b1;
        in_data[w]  = ct;
        while (!in_ready[w] && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("accept_ready", 128'(in_ready[w]), 128'd1);
        idx0 = rk_idx[w];
        @(negedge clk);
        in_valid[w] = 1'b0;
    endtask

    task automatic waitOutput(input int w, output int lat, output logic [63:0] seq);
        lat = 0;
        seq = '0;
        while (!out_valid[w] && lat < 60) begin
            seq = {seq[59:0], rk_idx[w]};
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        logic [3:0]   idx0;
        logic [63:0]  seq;
        logic [127:0] pta, ptb, cta, ctb;
        int lat, cnt;

        rst_n     = 1'b0;
        in_valid  = 2'b00;
        out_ready = 2'b11;
        in_data[0] = '0;
        in_data[1] = '0;
        for (int w = 0; w < 2; w++)
            for (int r = 0; r < 15; r++) ks[w][r] = '0;
        expandKey(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
        expandKey(1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);

        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready",  128'(in_ready[0]),  128'd1);
        checkOutput("rst_out_valid", 128'(out_valid[0]), 128'd0);
        checkOutput("rst_busy",      128'(busy[0]),      128'd0);
        checkOutput("rst_out_data",  out_data[0],        128'd0);
        checkOutput("rst_rk_idx10",  128'(rk_idx[0]),    128'd10);
        checkOutput("rst_rk_idx14",  128'(rk_idx[1]),    128'd14);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] FIPS-197 C.1");
        applyStimulus(0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, idx0);
        checkOutput("c1_busy_mid",     128'(busy[0]),     128'd1);
        checkOutput("c1_in_ready_mid", 128'(in_ready[0]), 128'd0);
        waitOutput(0, lat, seq);
        checkOutput("c1_latency",    128'(lat), 128'd10);
        checkOutput("c1_rk_idx_seq", 128'({idx0, seq[39:0]}), 128'h0A9876543210);
        checkOutput("c1_plaintext",  out_data[0], 128'h00112233445566778899aabbccddeeff);
        @(negedge clk);
        checkOutput("c1_out_valid_drop", 128'(out_valid[0]), 128'd0);
        checkOutput("c1_in_ready_back",  128'(in_ready[0]),  128'd1);

        $display("[TB] FIPS-197 C.3");
        applyStimulus(1, 128'h8ea2b7ca516745bfeafc49904b496089, idx0);
        waitOutput(1, lat, seq);
        checkOutput("c3_latency",   128'(lat), 128'd14);
        checkOutput("c3_plaintext", out_data[1], 128'h00112233445566778899aabbccddeeff);
        @(negedge clk);

        $display("[TB] backpressure");
        pta = 128'h3243f6a8885a308d313198a2e0370734;
        cta = encrypt(0, pta, 10);
        out_ready[0] = 1'b0;
        applyStimulus(0, cta, idx0);
        waitOutput(0, lat, seq);
        checkOutput("bp_plaintext", out_data[0], pta);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid[0] && out_data[0] === pta && !in_ready[0]) cnt++;
        end
        checkOutput("bp_hold_cycles", 128'(cnt), 128'd20);
        out_ready[0] = 1'b1;
        @(negedge clk);
        checkOutput("bp_out_valid_drop", 128'(out_valid[0]), 128'd0);
        checkOutput("bp_in_ready_back",  128'(in_ready[0]),  128'd1);

        $display("[TB] back-to-back");
        pta = 128'hdeadbeef0123456789abcdeffedcba98;
        ptb = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        cta = encrypt(0, pta, 10);
        ctb = encrypt(0, ptb, 10);
        checkOutput("b2b_ready_a", 128'(in_ready[0]), 128'd1);
        in_valid[0] = 1'b1;
        in_data[0]  = cta;
        @(negedge clk);
        in_data[0]  = ctb;
        waitOutput(0, lat, seq);
        checkOutput("b2b_latency_a", 128'(lat), 128'd10);
        checkOutput("b2b_plain_a",   out_data[0], pta);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!in_ready[0] && cnt < 20);
        checkOutput("b2b_gap", 128'(cnt), 128'd1);
        @(negedge clk);
        in_valid[0] = 1'b0;
        waitOutput(0, lat, seq);
        checkOutput("b2b_latency_b", 128'(lat), 128'd10);
        checkOutput("b2b_plain_b",   out_data[0], ptb);
        @(negedge clk);

        $display("[TB] busy-input ignore");
        pta = 128'h00000000000000000000000000000001;
        cta = encrypt(0, pta, 10);
        applyStimulus(0, cta, idx0);
        repeat (3) @(negedge clk);
        in_valid[0] = 1'b1;
        in_data[0]  = ~cta;
        repeat (2) @(negedge clk);
        in_valid[0] = 1'b0;
        in_data[0]  = '0;
        waitOutput(0, lat, seq);
        checkOutput("ign_latency_rest", 128'(lat), 128'd5);
        checkOutput("ign_plaintext",    out_data[0], pta);
        @(negedge clk);
        cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid[0] || busy[0]) cnt++;
        end
        checkOutput("ign_extra_activity", 128'(cnt), 128'd0);

        $display("[TB] reset mid-operation");
        pta = 128'hffeeddccbbaa99887766554433221100;
        cta = encrypt(0, pta, 10);
        applyStimulus(0, cta, idx0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("mid_rst_in_ready",  128'(in_ready[0]),  128'd1);
        checkOutput("mid_rst_out_valid", 128'(out_valid[0]), 128'd0);
        checkOutput("mid_rst_out_data",  out_data[0],        128'd0);
        checkOutput("mid_rst_busy",      128'(busy[0]),      128'd0);
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid[0]) cnt++;
        end
        checkOutput("mid_rst_no_output", 128'(cnt), 128'd0);
        ptb = 128'h0123456789abcdef0123456789abcdef;
        ctb = encrypt(0, ptb, 10);
        applyStimulus(0, ctb, idx0);
        waitOutput(0, lat, seq);
        checkOutput("post_rst_latency", 128'(lat), 128'd10);
        checkOutput("post_rst_plain",   out_data[0], ptb);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
